// File: rtl/gate_output_trigger_queue.sv
// Turns toggles on a gate result vector into a FIFO of gate indices, lowest index first.
// Optional pop counter output trig_count when GATE_TRIGGER_QUEUE_STATS_EN is defined.
module gate_output_trigger_queue #(
  parameter int unsigned GATE_COUNT = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          logic_reset,
  input  logic                          logic_flush,
  input  logic [GATE_COUNT-1:0]         gate_state,
  output logic                          trig_valid,
  input  logic                          trig_ready,
  output logic [$clog2(GATE_COUNT)-1:0] trig_idx,
  output logic                          coalesced,
  output logic                          busy
`ifdef GATE_TRIGGER_QUEUE_STATS_EN
  ,
  output logic [15:0]                   trig_count
`endif
);

  localparam int unsigned IDX_W = $clog2(GATE_COUNT);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t                r_state;
  logic [GATE_COUNT-1:0] r_prev;
  logic [GATE_COUNT-1:0] r_pending;
  logic [IDX_W-1:0]      r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_trig_valid;
  logic [IDX_W-1:0]      r_trig_idx;
  logic                  r_coalesced;
  logic                  r_busy;

  logic [GATE_COUNT-1:0] w_chg;
  logic [GATE_COUNT-1:0] w_sel;
  logic [GATE_COUNT-1:0] w_clr;
  logic [GATE_COUNT-1:0] w_pending_nxt;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_head_nxt;
  logic [PW-1:0]         w_wr_nxt;
  logic [PW-1:0]         w_rd_nxt;
  logic                  w_full;
  logic                  w_empty_nxt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_merge;

  // Lowest pending gate is the next one enqueued.
  always_comb begin
    w_sel_idx = '0;
    for (int i = GATE_COUNT - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_chg  = (r_state == ST_RUN) ? (gate_state ^ r_prev) : '0;
    w_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
             (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop  = r_trig_valid & trig_ready;
    w_sel  = r_pending & (~r_pending + GATE_COUNT'(1));
    w_push = (|r_pending) & (~w_full | w_pop);
    w_clr  = w_push ? w_sel : '0;
    // A fresh toggle on the bit being enqueued is a new trigger, not a merge.
    w_pending_nxt = (r_pending & ~w_clr) | w_chg;
    w_merge       = |(w_chg & r_pending & ~w_clr);
    w_wr_nxt      = r_wr_ptr + PW'(w_push);
    w_rd_nxt      = r_rd_ptr + PW'(w_pop);
    w_empty_nxt   = (w_wr_nxt == w_rd_nxt);
  end

  // Next show-ahead head, bypassing the entry written this cycle.
  always_comb begin
    w_head_nxt = '0;
    if (!w_empty_nxt) begin
      if (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
        w_head_nxt = w_sel_idx;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_sel_idx;
  end

  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) begin
      r_state      <= ST_ARM;
      r_prev       <= '0;
      r_pending    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_trig_valid <= 1'b0;
      r_trig_idx   <= '0;
      r_coalesced  <= 1'b0;
      r_busy       <= 1'b0;
    end else if (logic_flush) begin
      r_state      <= ST_ARM;
      r_prev       <= gate_state;
      r_pending    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_trig_valid <= 1'b0;
      r_trig_idx   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM:  r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_ARM;
      endcase
      r_prev       <= gate_state;
      r_pending    <= w_pending_nxt;
      r_wr_ptr     <= w_wr_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_trig_valid <= ~w_empty_nxt;
      r_trig_idx   <= w_head_nxt;
      r_busy       <= (|w_pending_nxt) | ~w_empty_nxt;
      if (w_merge) r_coalesced <= 1'b1;
    end
  end

  assign trig_valid = r_trig_valid;
  assign trig_idx   = r_trig_idx;
  assign coalesced  = r_coalesced;
  assign busy       = r_busy;

`ifdef GATE_TRIGGER_QUEUE_STATS_EN
  logic [15:0] r_trig_count;

  // Saturating pop counter; only reset clears it.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) begin
      r_trig_count <= '0;
    end else if (w_pop && (r_trig_count != 16'hFFFF)) begin
      r_trig_count <= r_trig_count + 16'd1;
    end
  end

  assign trig_count = r_trig_count;
`endif

endmodule
